free_tag_pool: RTL
==================

FREE_TAG_POOL -- requirements
Module: free_tag_pool

Interface
REQ-001 SHALL have parameter NUM_TAGS, default 7'd64, total physical tags p0..p63.
REQ-002 SHALL have parameter INIT_FREE_BASE, default 7'd32, lowest tag free after reset; p0..p31 hold initial architectural mappings.
REQ-003 SHALL have port clk, input, 1, sole clock; all state changes on posedge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port alloc_req, input, 1, Rename consumes one tag this cycle.
REQ-006 SHALL have port freed_tag_1, input, 6, first tag returned by ROB retirement; 0 means none.
REQ-007 SHALL have port freed_tag_2, input, 6, second tag returned by ROB retirement; 0 means none.
REQ-008 SHALL have port alloc_valid, output, 1, pool non-empty and alloc_tag meaningful.
REQ-009 SHALL have port alloc_tag, output, 6, tag at pool head; 0 when alloc_valid=0.
REQ-010 SHALL have port free_count, output, 7, number of tags currently in pool.
REQ-011 SHALL have port err_underflow, output, 1, sticky: alloc_req seen while alloc_valid=0.
REQ-012 SHALL have port err_double_free, output, 1, sticky: a freed tag was already in pool.

Function
REQ-013 SHALL store tags in a 64-entry circular FIFO with 6-bit head/tail pointers wrapping 63->0, plus a 7-bit count.
REQ-014 SHALL keep a 64-bit in_pool bitmap; bit 0 SHALL always be 0.
REQ-015 SHALL drive alloc_valid = (count != 0) and alloc_tag = fifo[head] combinationally from registered state; no free-to-alloc bypass.
REQ-016 SHALL, on alloc_req && alloc_valid, advance head by 1 and clear in_pool[alloc_tag] at the next posedge.
REQ-017 SHALL ignore alloc_req when alloc_valid=0 (no state change) and set err_underflow.
REQ-018 SHALL treat freed tag 0 as no-op, never inserting p0.
REQ-019 SHALL accept a nonzero freed tag only if its in_pool bit is 0, or if it equals the tag being allocated this same cycle; otherwise drop it and set err_double_free.
REQ-020 SHALL, when freed_tag_1 == freed_tag_2 != 0, insert it once and set err_double_free.
REQ-021 SHALL write accepted tags at tail in order freed_tag_1 then freed_tag_2; a lone accepted freed_tag_2 goes at tail; tail advances by accepted count (0-2) mod 64.
REQ-022 SHALL update count <= count + accepted_frees - alloc_done each cycle; simultaneous alloc and frees are all honoured.
REQ-023 SHALL never exceed count 63; guaranteed by the bitmap check, since only p1..p63 can be present.
REQ-024 SHALL make free_count registered and equal to count.
REQ-025 SHALL hold err_* high until reset once set.

Reset
REQ-026 SHALL on rst assertion, asynchronously: fifo[i] = INIT_FREE_BASE+i for i=0..31, head=0, tail=32, count=32, in_pool bits 32..63 set and others clear, err_* = 0.
REQ-027 SHALL after reset present alloc_valid=1, alloc_tag=32, free_count=32.
REQ-028 SHALL abandon any in-flight allocation or free on reset mid-operation; inputs sampled in a reset cycle have no effect.

Verification
REQ-029 Release rst -> alloc_valid=1, alloc_tag=32, free_count=32, errors 0.
REQ-030 alloc_req for 32 cycles -> tags 32..63 in order, then alloc_valid=0, alloc_tag=0, free_count=0; one more alloc_req -> err_underflow=1, count stays 0.
REQ-031 From empty, free (5,9) in one cycle -> free_count=2, alloc_tag=5; alloc -> alloc_tag=9; free (0,7) -> only 7 added.
REQ-032 Free 40 while 40 is in pool -> err_double_free=1, free_count unchanged; free (12,12) -> count +1, err_double_free=1.
REQ-033 At count=32, alloc_req with free (3,4) same cycle -> count=33, 3 and 4 at tail behind 63; 200 cycles of paired alloc/free -> FIFO order preserved across pointer wrap.
REQ-034 Assert rst mid-burst with count=17 -> outputs immediately return to REQ-027 values, independent of clk.

Source files
------------

// File: rtl/free_tag_pool.sv
// Free physical-tag pool for register renaming.
// Holds the physical tags that are not currently mapped. The tags live in a
// circular FIFO. A bitmap records which tags are in the pool, so a tag that
// is returned twice can be detected and dropped. Rename takes tags from the
// head of the FIFO. ROB retirement returns up to two tags per cycle, which
// are written at the tail.
module free_tag_pool #(
    parameter logic [6:0] NUM_TAGS       = 7'd64,
    parameter logic [6:0] INIT_FREE_BASE = 7'd32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       alloc_req,
    input  logic [5:0] freed_tag_1,
    input  logic [5:0] freed_tag_2,
    output logic       alloc_valid,
    output logic [5:0] alloc_tag,
    output logic [6:0] free_count,
    output logic       err_underflow,
    output logic       err_double_free
);

    localparam int DEPTH = int'(NUM_TAGS);
    localparam int NINIT = int'(NUM_TAGS) - int'(INIT_FREE_BASE);

    logic [5:0]       fifo [DEPTH];
    logic [5:0]       head;
    logic [5:0]       tail;
    logic [6:0]       count;
    logic [DEPTH-1:0] in_pool;

    logic             alloc_done;
    logic             acc1;
    logic             acc2;
    logic             dup;
    logic             dbl_free;
    logic [1:0]       acc_cnt;
    logic [5:0]       slot2;
    logic [5:0]       tail_next;
    logic [6:0]       count_next;
    logic [DEPTH-1:0] pool_next;

    // Head of the pool is presented straight from registered state (no bypass)
    always_comb begin
        alloc_valid = (count != 7'd0);
        alloc_tag   = alloc_valid ? fifo[head] : 6'd0;
        free_count  = count;
    end

    // Decide which returned tags are accepted and derive the next pointers and bitmap
    always_comb begin
        alloc_done = alloc_req && alloc_valid;
        dup        = (freed_tag_2 != 6'd0) && (freed_tag_2 == freed_tag_1);
        // A tag that is handed out this very cycle may come straight back.
        acc1 = (freed_tag_1 != 6'd0) &&
               (!in_pool[freed_tag_1] || (alloc_done && freed_tag_1 == alloc_tag));
        acc2 = (freed_tag_2 != 6'd0) && !dup &&
               (!in_pool[freed_tag_2] || (alloc_done && freed_tag_2 == alloc_tag));
        dbl_free = ((freed_tag_1 != 6'd0) && !acc1) ||
                   ((freed_tag_2 != 6'd0) && !dup && !acc2) ||
                   dup;
        acc_cnt    = {1'b0, acc1} + {1'b0, acc2};
        // A lone accepted second tag takes the tail slot itself.
        slot2      = tail + {5'd0, acc1};
        tail_next  = tail + {4'd0, acc_cnt};
        count_next = count + {5'd0, acc_cnt} - {6'd0, alloc_done};
        pool_next  = in_pool;
        // Clear before set, so a tag re-freed in its allocation cycle stays present.
        if (alloc_done) pool_next[alloc_tag] = 1'b0;
        if (acc1)       pool_next[freed_tag_1] = 1'b1;
        if (acc2)       pool_next[freed_tag_2] = 1'b1;
        pool_next[0] = 1'b0;
    end

    // Tag storage: preloaded with the initially free tags, then written at the tail
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo[i] <= (i < NINIT) ? 6'(int'(INIT_FREE_BASE) + i) : 6'd0;
            end
        end else begin
            if (acc1) fifo[tail]  <= freed_tag_1;
            if (acc2) fifo[slot2] <= freed_tag_2;
        end
    end

    // Pointers, occupancy, membership bitmap and sticky error flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head            <= 6'd0;
            tail            <= 6'(NINIT);
            count           <= 7'(NINIT);
            err_underflow   <= 1'b0;
            err_double_free <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                in_pool[i] <= (i >= int'(INIT_FREE_BASE));
            end
        end else begin
            if (alloc_done) head <= head + 6'd1;
            tail    <= tail_next;
            count   <= count_next;
            in_pool <= pool_next;
            if (alloc_req && !alloc_valid) err_underflow   <= 1'b1;
            if (dbl_free)                  err_double_free <= 1'b1;
        end
    end

endmodule
